// File: rtl/eth_tx_arbiter.sv
// Frame-level two-port AXI-Stream round-robin arbiter feeding the MAC transmit FIFO.
// Optional stall watchdog enabled by defining ETH_TX_ARB_TIMEOUT_EN.
module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int IFG_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tuser,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  abort_pulse
);

    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
`ifdef ETH_TX_ARB_TIMEOUT_EN
        , S_ABORT
        , S_DRAIN
`endif
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t          state, state_nxt;
    logic            sel, sel_nxt;
    logic            rr, rr_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic            g_ready;

    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid, g_last, g_user;

    assign g_data  = sel ? s1_axis_tdata  : s0_axis_tdata;
    assign g_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign g_last  = sel ? s1_axis_tlast  : s0_axis_tlast;
    assign g_user  = sel ? s1_axis_tuser  : s0_axis_tuser;

`ifdef ETH_TX_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_cnt, wd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_cnt <= '0;
        else     wd_cnt <= wd_nxt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sel     <= 1'b0;
            rr      <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            rr      <= rr_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        rr_nxt        = rr;
        gap_nxt       = gap_cnt;
        g_ready       = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        abort_pulse   = 1'b0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
        wd_nxt        = wd_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    sel_nxt   = (s0_axis_tvalid && s1_axis_tvalid) ? rr : s1_axis_tvalid;
                    state_nxt = S_GRANT;
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    wd_nxt    = '0;
`endif
                end
            end
            S_GRANT: begin
                m_axis_tdata  = g_data;
                m_axis_tvalid = g_valid;
                m_axis_tlast  = g_last;
                m_axis_tuser  = g_user;
                g_ready       = m_axis_tready;
                if (g_valid && m_axis_tready) begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    wd_nxt = '0;
`endif
                    if (g_last) begin
                        rr_nxt    = ~sel;
                        gap_nxt   = '0;
                        state_nxt = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
                end
`ifdef ETH_TX_ARB_TIMEOUT_EN
                // Abort on the stall cycle that brings the count to TIMEOUT.
                else if (!g_valid) begin
                    if (wd_cnt == WW'(TIMEOUT - 1)) begin
                        abort_pulse = 1'b1;
                        state_nxt   = S_ABORT;
                    end else begin
                        wd_nxt = wd_cnt + 1'b1;
                    end
                end
`endif
            end
            S_GAP: begin
                if (gap_cnt == GW'(IFG_CYCLES - 1)) state_nxt = S_IDLE;
                else                                gap_nxt   = gap_cnt + 1'b1;
            end
`ifdef ETH_TX_ARB_TIMEOUT_EN
            S_ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                g_ready = 1'b1;
                if (g_valid && g_last) begin
                    rr_nxt    = ~rr;
                    gap_nxt   = '0;
                    state_nxt = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    logic granted;
`ifdef ETH_TX_ARB_TIMEOUT_EN
    assign granted = (state == S_GRANT) || (state == S_ABORT) || (state == S_DRAIN);
`else
    assign granted = (state == S_GRANT);
`endif

    assign grant          = granted ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign busy           = (state != S_IDLE);
    assign s0_axis_tready = g_ready && !sel;
    assign s1_axis_tready = g_ready && sel;

endmodule
